// File: rtl/imem_prog.sv
// Boot-loadable instruction memory: sequential load port, fetch with 1-cycle registered response.
// Fetch response holds stable under rsp_ready backpressure; req_ready drops until it retires.
module imem_prog #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 64,
  parameter  int ADDR_W = 32,
  localparam int AL     = $clog2(DATA_W / 8),
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic [IW-1:0]     ld_base,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic [IW:0]       ld_count,
  output logic              ld_ovf,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'((1 << AL) - 1);

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  loaded;
  logic [IW:0]       ptr;

  logic [ADDR_W-1:0] word;
  logic [IW-1:0]     idx;
  logic              misal, oor;
  logic              ld_hs, req_hs, start_ok, wr_en;
  logic [1:0]        err_n;
  logic [DATA_W-1:0] data_n;

  assign ld_ready  = (state == LOAD);
  assign busy      = (state == LOAD);
  assign req_ready = (state == RUN) && (!rsp_valid || rsp_ready);

  assign ld_hs    = ld_valid && ld_ready;
  assign req_hs   = req_valid && req_ready;
  // A reload may not tear down a response the fetch stage has not yet consumed.
  assign start_ok = ld_start && ((state != RUN) || !rsp_valid);
  // ptr[IW] set means the load ran past the last word; such words are dropped.
  assign wr_en    = ld_hs && !ld_start && !ptr[IW];

  assign word  = req_addr >> AL;
  assign idx   = word[IW-1:0];
  assign misal = (req_addr & AMASK) != '0;
  assign oor   = (word >> IW) != '0;

  always_comb begin
    err_n  = 2'b00;
    data_n = '0;
    if (misal)
      err_n = 2'b01;
    else if (oor)
      err_n = 2'b10;
    else if (!loaded[idx])
      err_n = 2'b11;
    else
      data_n = mem[idx];
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[ptr[IW-1:0]] <= ld_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      ld_count  <= '0;
      ld_ovf    <= 1'b0;
      loaded    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 2'b00;
    end else begin
      if (req_hs) begin
        rsp_valid <= 1'b1;
        rsp_data  <= data_n;
        rsp_err   <= err_n;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      if (start_ok) begin
        state    <= LOAD;
        ptr      <= {1'b0, ld_base};
        ld_count <= '0;
        ld_ovf   <= 1'b0;
      end else if (ld_hs) begin
        if (ptr[IW]) begin
          ld_ovf <= 1'b1;
        end else begin
          loaded[ptr[IW-1:0]] <= 1'b1;
          ptr                 <= ptr + 1'b1;
          ld_count            <= ld_count + 1'b1;
        end
        if (ld_last)
          state <= RUN;
      end
    end
  end

endmodule
